// File: rtl/lsu_ram_adapter.sv
// Load/store adapter: turns byte/half/word core requests into word-addressed, byte-enabled RAM
// accesses and returns lane-extracted, sign/zero-extended load data two cycles after acceptance.
module lsu_ram_adapter #(
   parameter int ADDR_WIDTH = 10
) (
   input  logic                  clk_i,
   input  logic                  rstn_i,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [1:0]            req_size_i,
   input  logic                  req_unsigned_i,
   input  logic [31:0]           req_addr_i,
   input  logic [31:0]           req_wdata_i,
   output logic                  rsp_valid_o,
   output logic [31:0]           rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic [3:0]            ram_we_o,
   output logic [ADDR_WIDTH-1:0] ram_addr_o,
   output logic [31:0]           ram_wdata_o,
   input  logic [31:0]           ram_rdata_i
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t     state, state_nxt;
   logic       accept;
   logic       req_err;
   logic [1:0] size_p1;
   logic [1:0] off_p1;
   logic       uns_p1;
   logic       store_p1;
   logic       err_p1;
   logic       unused_addr;

   function automatic logic access_err(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   access_err = 1'b0;
         2'b01:   access_err = off[0];
         2'b10:   access_err = (off != 2'b00);
         default: access_err = 1'b1;
      endcase
   endfunction

   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
      case (size)
         2'b00:   byte_en = 4'b0001 << off;
         2'b01:   byte_en = 4'b0011 << off;
         default: byte_en = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] wdata);
      case (size)
         2'b00:   lane_rep = {4{wdata[7:0]}};
         2'b01:   lane_rep = {2{wdata[15:0]}};
         default: lane_rep = wdata;
      endcase
   endfunction

   // Shift the addressed lane down to bit 0, then extend to the full word.
   function automatic logic [31:0] load_extract(input logic [31:0] rdata, input logic [1:0] size,
                                                input logic [1:0] off, input logic uns);
      logic        [31:0] shifted;
      logic signed [7:0]  b8;
      logic signed [15:0] h16;
      logic signed [31:0] res;
      shifted = rdata >> {off, 3'b000};
      b8      = shifted[7:0];
      h16     = shifted[15:0];
      case (size)
         2'b00:   res = uns ? $signed({24'd0, shifted[7:0]})  : 32'(b8);
         2'b01:   res = uns ? $signed({16'd0, shifted[15:0]}) : 32'(h16);
         default: res = $signed(rdata);
      endcase
      load_extract = res;
   endfunction

   assign req_ready_o = (state != ISSUE);
   assign accept      = req_valid_i && req_ready_o;
   assign req_err     = access_err(req_size_i, req_addr_i[1:0]);
   assign unused_addr = ^req_addr_i[31:ADDR_WIDTH+2];

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    state_nxt = accept ? ISSUE : IDLE;
         ISSUE:   state_nxt = RESP;
         RESP:    state_nxt = accept ? ISSUE : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Acceptance -> ISSUE: RAM controls are registered here, so write enables live for ISSUE only.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         ram_we_o    <= '0;
         ram_addr_o  <= '0;
         ram_wdata_o <= '0;
         size_p1     <= '0;
         off_p1      <= '0;
         uns_p1      <= 1'b0;
         store_p1    <= 1'b0;
         err_p1      <= 1'b0;
      end else begin
         ram_we_o <= '0;
         if (accept) begin
            ram_addr_o <= req_addr_i[ADDR_WIDTH+1:2];
            size_p1    <= req_size_i;
            off_p1     <= req_addr_i[1:0];
            uns_p1     <= req_unsigned_i;
            store_p1   <= req_we_i;
            err_p1     <= req_err;
            if (req_we_i && !req_err) begin
               ram_we_o    <= byte_en(req_size_i, req_addr_i[1:0]);
               ram_wdata_o <= lane_rep(req_size_i, req_wdata_i);
            end
         end
      end
   end

   // RESP: RAM read data arrives this cycle and is formatted combinationally.
   assign rsp_valid_o = (state == RESP);
   assign rsp_err_o   = rsp_valid_o && err_p1;
   assign rsp_rdata_o = (rsp_valid_o && !err_p1 && !store_p1)
                        ? load_extract(ram_rdata_i, size_p1, off_p1, uns_p1) : 32'd0;

endmodule
